instr_dispatch: RTL

//  Instruction sequencer for the microcontroller core. Accepts one 16-bit instruction at a time,

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/op_decode.sv | 25 ++
 rtl/instr_dispatch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the core: opcode map, execution-unit indices and
// dispatcher state encodings.
package cpu_pkg;

   localparam int CPU_IW    = 16;
   localparam int CPU_NUNIT = 4;
   localparam int UIDX_W    = 2;

   localparam logic [3:0] OPC_NOP      = 4'h0;
   localparam logic [3:0] OPC_ALUI     = 4'h1;
   localparam logic [3:0] OPC_ALUI_ALT = 4'h2;
   localparam logic [3:0] OPC_ALU_REG  = 4'h3;
   localparam logic [3:0] OPC_MOV      = 4'h4;
   localparam logic [3:0] OPC_LOAD     = 4'h5;

   localparam logic [UIDX_W-1:0] UNIT_ALUI    = 2'd0;
   localparam logic [UIDX_W-1:0] UNIT_ALU_REG = 2'd1;
   localparam logic [UIDX_W-1:0] UNIT_MOV     = 2'd2;
   localparam logic [UIDX_W-1:0] UNIT_LOAD    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_RETIRE = 3'd4,
      S_ERR    = 3'd5
   } disp_state_e;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier; also used by the disassembler monitor.
module op_decode
   import cpu_pkg::*;
(
   input  logic [3:0]        opcode,
   output logic              is_nop,
   output logic              is_illegal,
   output logic [UIDX_W-1:0] unit_idx
);

   always_comb begin
      is_nop     = 1'b0;
      is_illegal = 1'b0;
      unit_idx   = UNIT_ALUI;
      case (opcode)
         OPC_NOP:                is_nop   = 1'b1;
         OPC_ALUI, OPC_ALUI_ALT: unit_idx = UNIT_ALUI;
         OPC_ALU_REG:            unit_idx = UNIT_ALU_REG;
         OPC_MOV:                unit_idx = UNIT_MOV;
         OPC_LOAD:               unit_idx = UNIT_LOAD;
         default:                is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_dispatch.sv
// Instruction sequencer: latches one instruction, starts exactly one execution
// unit, waits for its done (with watchdog) and retires it.
module instr_dispatch
   import cpu_pkg::*;
#(
   parameter int IW       = CPU_IW,
   parameter int NUNIT    = CPU_NUNIT,
   parameter int WDOG_MAX = 15,
   parameter int CNTW     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [IW-1:0]    instr,
   output logic             instr_ready,
   output logic [IW-1:0]    ir,
   output logic [NUNIT-1:0] unit_start,
   input  logic [NUNIT-1:0] unit_done,
   input  logic             err_clr,
   output logic             busy,
   output logic             illegal_op,
   output logic             timeout_err,
   output logic [CNTW-1:0]  retired,
   output disp_state_e      state
);

   localparam int WDOG_W = 8;

   // Fetch handshake: an instruction transfers on a rising edge where
   // instr_valid && instr_ready; ready is high only in IDLE, so nothing is dropped.

   disp_state_e       next_state;
   logic              dec_nop;
   logic              dec_illegal;
   logic [UIDX_W-1:0] dec_idx;
   logic [UIDX_W-1:0] uidx;
   logic [WDOG_W-1:0] wdog;
   logic              wdog_expired;
   logic              done_hit;

   op_decode u_op_decode (
      .opcode     (ir[IW-1 -: 4]),
      .is_nop     (dec_nop),
      .is_illegal (dec_illegal),
      .unit_idx   (dec_idx)
   );

   assign wdog_expired = (wdog == WDOG_W'(WDOG_MAX));
   assign done_hit     = unit_done[uidx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (instr_valid) next_state = S_DECODE;
         S_DECODE: begin
            if (dec_nop)          next_state = S_RETIRE;
            else if (dec_illegal) next_state = S_ERR;
            else                  next_state = S_START;
         end
         S_START:  next_state = S_WAIT;
         // A done arriving on the expiry cycle takes priority over the trap.
         S_WAIT: begin
            if (done_hit)          next_state = S_RETIRE;
            else if (wdog_expired) next_state = S_ERR;
         end
         S_RETIRE: next_state = S_IDLE;
         S_ERR:    if (err_clr) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (state == S_IDLE);
      busy        = (state != S_IDLE) && (state != S_ERR);
      unit_start  = '0;
      if (state == S_START) unit_start[uidx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir          <= '0;
         uidx        <= '0;
         wdog        <= '0;
         retired     <= '0;
         illegal_op  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE:   if (instr_valid) ir <= instr;
            S_DECODE: begin
               uidx <= dec_idx;
               if (dec_illegal && !dec_nop) illegal_op <= 1'b1;
            end
            S_START:  wdog <= '0;
            S_WAIT: begin
               wdog <= wdog + WDOG_W'(1);
               if (!done_hit && wdog_expired) timeout_err <= 1'b1;
            end
            // Clearing ir drops opcode-gated units back to their idle state.
            S_RETIRE: begin
               retired <= retired + CNTW'(1);
               ir      <= '0;
            end
            S_ERR: begin
               ir <= '0;
               if (err_clr) begin
                  illegal_op  <= 1'b0;
                  timeout_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
